keypad_entry: RTL and testbench
===============================

// Module: keypad_entry
// PURPOSE
//  Downstream of the 4x4 keypad scanner. Turns its level-style key code into single press events.
//  Accumulates the pressed digits into a multi-digit number.
//  Posts the finished number to the CPU MMIO input port with a valid/ack handshake.
//  Also exports the live, in-progress entry for the seven-segment display.
// PARAMETERS
//  DATA_W         16  width of entry/posted value; hex mode holds DATA_W/4 digits
//  SETTLE_CYCLES  8   consecutive clk cycles key_valid must stay high before the digit is taken
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  key_val     in   4       scanner key code 0x0-0xF (scanner domain, treated async)
//  key_valid   in   1       scanner key-pressed flag, high while a key is held (async)
//  btn_enter   in   1       debounced enter button, level (async)
//  btn_clear   in   1       debounced clear button, level (async)
//  rd_ack      in   1       CPU read acknowledge, 1-cycle pulse, clk domain
//  entry_val   out  DATA_W  live entry value (display)
//  digit_cnt   out  4       digits currently in entry
//  overflow    out  1       sticky: a digit was rejected since the last clear/enter
//  data_out    out  DATA_W  posted value
//  data_valid  out  1       posted value unread
// BEHAVIOUR
//  Reset: all outputs 0, FSM in S_IDLE, all synchronizer flops 0, settle counter 0.
//  Sync: key_val, key_valid, btn_enter and btn_clear each pass through 2 FFs.
//   enter/clear events = rising edge of the synced level (1-cycle pulse).
//  FSM, clocked on clk:
//   S_IDLE:   synced key_valid=1 -> S_SETTLE, counter <= 1.
//   S_SETTLE: key_valid=0 -> S_IDLE, no digit taken (glitch).
//             counter reaches SETTLE_CYCLES -> sample synced key_val, accept digit, go to S_HELD.
//             Otherwise counter++.
//   S_HELD:   stay until key_valid=0, then -> S_IDLE. A held key yields exactly one digit.
//  Digit accept, hex mode:
//   digit_cnt < DATA_W/4: entry <= {entry[DATA_W-5:0], key}, digit_cnt++.
//   Else: entry unchanged, overflow <= 1.
//  Enter event:
//   data_valid=0: data_out <= entry, data_valid <= 1; clear entry, digit_cnt and overflow.
//   data_valid=1 and no rd_ack this cycle: enter ignored, entry kept.
//  rd_ack with data_valid=1: data_valid <= 0 next cycle.
//   rd_ack and enter in the same cycle: the new value posts and data_valid stays 1.
//  Clear event: entry, digit_cnt, overflow <= 0. data_out and data_valid are untouched.
//  Priority within one cycle: clear > enter > digit accept. A losing digit is discarded; FSM still goes to S_HELD.
//  Results are visible on outputs the cycle after the event.
//  Press-to-entry latency = 2 (sync) + SETTLE_CYCLES + 1 clk.
// CONFIGURATION
//  KEYPAD_DECIMAL_EN defined:
//   Codes 0xA-0xF are ignored: no digit, no overflow.
//   Accept computes entry*10 + key in DATA_W+4 bits.
//    Result > 2^DATA_W-1: rejected, overflow <= 1.
//    Otherwise: entry <= result, digit_cnt++ (saturates at 15).
//  KEYPAD_DECIMAL_EN undefined: hex shift mode as above.
// STRUCTURE
//  keypad_pkg: DIGIT_W=4, FSM state typedef (S_IDLE/S_SETTLE/S_HELD), DEC_RADIX=10.
//  Sub-module sync_edge: 2-FF synchronizer plus rising-edge pulse output.
//   Instanced for key_valid, btn_enter and btn_clear.
//   key_val uses a plain 2-FF bus sync; it is stable while key_valid is settling.
// TESTING
//  Hex mode (DATA_W=16, SETTLE_CYCLES=8):
//  1. Keys 1,2,3, then enter -> data_out=0x0123, data_valid=1, entry_val=0, digit_cnt=0.
//     Then rd_ack -> data_valid=0.
//  2. Keys 1,2,3,4,5 -> entry_val=0x1234, digit_cnt=4, overflow=1.
//     Then clear -> entry_val=0, overflow=0.
//  3. key_valid high for 3 clk only -> no digit accepted.
//     Key 7 held 1000 clk -> entry_val=0x0007, a single digit.
//  4. Post 0x00AB, leave it unread, type 5 and enter -> data_out stays 0x00AB, entry_val=0x0005.
//     Then enter together with rd_ack -> data_out=0x0005, data_valid=1.
//  Other:
//  5. KEYPAD_DECIMAL_EN: keys 6,5,5,3,5 -> entry_val=65535.
//     Key 1 -> rejected, overflow=1. Key 0xC -> ignored.
//  6. Assert rst during S_SETTLE with data_valid=1 -> all outputs 0.
//     After release, a new key 9 gives entry_val=9.

Source files
------------

// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared constants and FSM state type for the keypad entry block
// Rev 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DEC_RADIX = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// sync_edge : 2-FF synchronizer with a 1-cycle rising-edge pulse output
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/keypad_entry.sv
// ============================================================================
// keypad_entry : keypad press debouncer, multi-digit accumulator and MMIO post
//   Define KEYPAD_DECIMAL_EN for decimal accumulation; default is hex shift.
// Rev 1.0
// ============================================================================
`default_nettype none

module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_val,
  input  logic              key_valid,
  input  logic              btn_enter,
  input  logic              btn_clear,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] entry_val,
  output logic [3:0]        digit_cnt,
  output logic              overflow,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYCLES);

  logic [DIGIT_W-1:0] r_key_s1;
  logic [DIGIT_W-1:0] r_key_s2;
  logic               w_kv;
  logic               w_kv_rise_unused;
  logic               w_enter;
  logic               w_enter_level_unused;
  logic               w_clear;
  logic               w_clear_level_unused;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;

  logic [DATA_W-1:0]  r_entry;
  logic [3:0]         r_digit_cnt;
  logic               r_overflow;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_data_valid;

  logic               w_take;
  logic               w_reject;
  logic [DATA_W-1:0]  w_next_entry;
  logic [3:0]         w_next_cnt;

  sync_edge u_sync_kv (
    .clk     (clk),
    .rst     (rst),
    .i_d     (key_valid),
    .o_level (w_kv),
    .o_rise  (w_kv_rise_unused)
  );

  sync_edge u_sync_enter (
    .clk     (clk),
    .rst     (rst),
    .i_d     (btn_enter),
    .o_level (w_enter_level_unused),
    .o_rise  (w_enter)
  );

  sync_edge u_sync_clear (
    .clk     (clk),
    .rst     (rst),
    .i_d     (btn_clear),
    .o_level (w_clear_level_unused),
    .o_rise  (w_clear)
  );

  // key_val is stable for the whole settle window, so a plain bus sync is safe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_s1 <= '0;
      r_key_s2 <= '0;
    end else begin
      r_key_s1 <= key_val;
      r_key_s2 <= r_key_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_kv) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (!w_kv)
            r_state <= S_IDLE;
          else if (r_cnt == c_settle)
            r_state <= S_HELD;
          else
            r_cnt <= r_cnt + CNT_W'(1);
        end
        S_HELD: begin
          if (!w_kv)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_accept = (r_state == S_SETTLE) && w_kv && (r_cnt == c_settle);

`ifdef KEYPAD_DECIMAL_EN
  localparam int PROD_W = DATA_W + DIGIT_W;
  localparam logic [PROD_W-1:0] c_max = {{DIGIT_W{1'b0}}, {DATA_W{1'b1}}};
  logic [PROD_W-1:0] w_prod;
`endif

  always_comb begin
    w_take       = 1'b0;
    w_reject     = 1'b0;
    w_next_entry = r_entry;
    w_next_cnt   = r_digit_cnt;
`ifdef KEYPAD_DECIMAL_EN
    // entry*10 < 16*entry, so DIGIT_W extra bits always hold the product
    w_prod = PROD_W'(r_entry) * PROD_W'(DEC_RADIX) + PROD_W'(r_key_s2);
    if (r_key_s2 < DIGIT_W'(DEC_RADIX)) begin
      if (w_prod > c_max) begin
        w_reject = 1'b1;
      end else begin
        w_take       = 1'b1;
        w_next_entry = w_prod[DATA_W-1:0];
        w_next_cnt   = (r_digit_cnt == 4'hF) ? 4'hF : r_digit_cnt + 4'd1;
      end
    end
`else
    if (int'(r_digit_cnt) < DATA_W / DIGIT_W) begin
      w_take       = 1'b1;
      w_next_entry = {r_entry[DATA_W-DIGIT_W-1:0], r_key_s2};
      w_next_cnt   = r_digit_cnt + 4'd1;
    end else begin
      w_reject = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry      <= '0;
      r_digit_cnt  <= '0;
      r_overflow   <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (rd_ack && r_data_valid)
        r_data_valid <= 1'b0;
      // clear beats enter beats digit; a digit losing here is simply dropped
      if (w_clear) begin
        r_entry     <= '0;
        r_digit_cnt <= '0;
        r_overflow  <= 1'b0;
      end else if (w_enter) begin
        if (!r_data_valid || rd_ack) begin
          r_data_out   <= r_entry;
          r_data_valid <= 1'b1;
          r_entry      <= '0;
          r_digit_cnt  <= '0;
          r_overflow   <= 1'b0;
        end
      end else if (w_accept) begin
        if (w_take) begin
          r_entry     <= w_next_entry;
          r_digit_cnt <= w_next_cnt;
        end
        if (w_reject)
          r_overflow <= 1'b1;
      end
    end
  end

  assign entry_val  = r_entry;
  assign digit_cnt  = r_digit_cnt;
  assign overflow   = r_overflow;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ============================================================================
// tb_keypad_entry : directed + randomized bench against a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_keypad_entry;

  localparam int DATA_W = 16;
  localparam int SETTLE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        key_val;
  logic              key_valid;
  logic              btn_enter;
  logic              btn_clear;
  logic              rd_ack;
  logic [DATA_W-1:0] entry_val;
  logic [3:0]        digit_cnt;
  logic              overflow;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what a user would see after each completed operation
  int unsigned m_entry;
  int unsigned m_cnt;
  int unsigned m_ovf;
  int unsigned m_out;
  int unsigned m_valid;

  always #5 clk = ~clk;

  keypad_entry #(
    .DATA_W        (DATA_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_val    (key_val),
    .key_valid  (key_valid),
    .btn_enter  (btn_enter),
    .btn_clear  (btn_clear),
    .rd_ack     (rd_ack),
    .entry_val  (entry_val),
    .digit_cnt  (digit_cnt),
    .overflow   (overflow),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".entry"}, 32'(entry_val), m_entry);
    check_eq({tag, ".cnt"},   32'(digit_cnt), m_cnt);
    check_eq({tag, ".ovf"},   32'(overflow),  m_ovf);
    check_eq({tag, ".out"},   32'(data_out),  m_out);
    check_eq({tag, ".valid"}, 32'(data_valid), m_valid);
  endtask

  task automatic model_reset();
    m_entry = 0; m_cnt = 0; m_ovf = 0; m_out = 0; m_valid = 0;
  endtask

  task automatic model_key(input int unsigned k);
`ifdef KEYPAD_DECIMAL_EN
    int unsigned r;
    if (k <= 9) begin
      r = m_entry * 10 + k;
      if (r > 65535) m_ovf = 1;
      else begin
        m_entry = r;
        m_cnt   = (m_cnt >= 15) ? 15 : m_cnt + 1;
      end
    end
`else
    if (m_cnt < DATA_W / 4) begin
      m_entry = ((m_entry << 4) | k) & 32'hFFFF;
      m_cnt   = m_cnt + 1;
    end else begin
      m_ovf = 1;
    end
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key held for 'hold' cycles; only holds longer than the settle window count
  task automatic press_key(input logic [3:0] k, input int hold);
    @(negedge clk);
    key_val   = k;
    key_valid = 1'b1;
    tick(hold);
    key_valid = 1'b0;
    tick(4);
    if (hold > SETTLE) model_key(32'(k));
  endtask

  // rd_ack is timed to coincide with the synchronized enter pulse
  task automatic press_enter(input logic ack);
    @(negedge clk);
    btn_enter = 1'b1;
    tick(2);
    rd_ack = ack;
    tick(1);
    rd_ack    = 1'b0;
    btn_enter = 1'b0;
    tick(3);
    if (m_valid == 0 || ack) begin
      m_out = m_entry; m_valid = 1; m_entry = 0; m_cnt = 0; m_ovf = 0;
    end
  endtask

  task automatic press_clear();
    @(negedge clk);
    btn_clear = 1'b1;
    tick(3);
    btn_clear = 1'b0;
    tick(3);
    m_entry = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic cpu_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    tick(1);
    m_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst = 1'b1; key_val = 4'h0; key_valid = 1'b0;
    btn_enter = 1'b0; btn_clear = 1'b0; rd_ack = 1'b0;
    model_reset();
    tick(3);
    check_all("reset");
    rst = 1'b0;
    tick(2);

`ifndef KEYPAD_DECIMAL_EN
    press_key(4'h1, SETTLE + 2);
    press_key(4'h2, SETTLE + 1);
    press_key(4'h3, 20);
    press_enter(1'b0);
    check_eq("t1.out", 32'(data_out), 32'h0123);
    check_eq("t1.valid", 32'(data_valid), 1);
    check_all("t1");
    cpu_ack();
    check_eq("t1.ack", 32'(data_valid), 0);

    for (int i = 1; i <= 5; i++) press_key(4'(i), 12);
    check_eq("t2.entry", 32'(entry_val), 32'h1234);
    check_eq("t2.ovf", 32'(overflow), 1);
    check_all("t2");
    press_clear();
    check_all("t2.clr");

    press_key(4'h5, 3);
    press_key(4'h6, SETTLE);
    check_eq("t3.glitch", 32'(entry_val), 0);
    press_key(4'h7, 1000);
    check_eq("t3.entry", 32'(entry_val), 32'h0007);
    check_eq("t3.cnt", 32'(digit_cnt), 1);

    press_clear();
    press_key(4'hA, 12);
    press_key(4'hB, 12);
    press_enter(1'b0);
    press_key(4'h5, 12);
    press_enter(1'b0);
    check_eq("t4.keep", 32'(data_out), 32'h00AB);
    check_eq("t4.entry", 32'(entry_val), 32'h0005);
    check_all("t4a");
    press_enter(1'b1);
    check_eq("t4.post", 32'(data_out), 32'h0005);
    check_eq("t4.valid", 32'(data_valid), 1);
    check_all("t4b");
    cpu_ack();
`else
    press_key(4'h6, 12);
    press_key(4'h5, 12);
    press_key(4'h5, 12);
    press_key(4'h3, 12);
    press_key(4'h5, 12);
    check_eq("t5.entry", 32'(entry_val), 65535);
    check_eq("t5.ovf0", 32'(overflow), 0);
    press_key(4'h1, 12);
    check_eq("t5.rej", 32'(entry_val), 65535);
    check_eq("t5.ovf", 32'(overflow), 1);
    press_key(4'hC, 12);
    check_eq("t5.ign", 32'(digit_cnt), 5);
    check_all("t5");
    press_clear();
    check_all("t5.clr");
`endif

    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4)      press_key(4'($urandom_range(0, 15)), int'($urandom_range(SETTLE + 1, 30)));
      else if (op == 5) press_key(4'($urandom_range(0, 15)), int'($urandom_range(1, SETTLE)));
      else if (op == 6) press_enter(1'($urandom_range(0, 1)));
      else if (op == 7) press_clear();
      else if (op == 8) cpu_ack();
      else              press_key(4'($urandom_range(0, 9)), int'($urandom_range(SETTLE + 1, 15)));
      check_all($sformatf("rnd%0d", i));
    end

    // reset while a key is mid-settle and a posted value is unread
    press_key(4'h4, 12);
    press_enter(1'b1);
    @(negedge clk);
    key_val = 4'h3; key_valid = 1'b1;
    tick(6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6.rst");
    key_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    press_key(4'h9, 12);
    check_eq("t6.entry", 32'(entry_val), 9);
    check_all("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
